imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the single-cycle RISC-V core.
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes the words into instruction memory through its write port and verifies an 8-bit checksum.
- Releases the core (cpu_run) only after a clean load; the core stays halted throughout loading.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- start  input  1  load request pulse; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte accepted when in_valid & in_ready at a clock edge.
- we  output  1  instruction-memory write enable, one-cycle pulse per word.
- waddr  output  ADDR_W  instruction-memory word address.
- wdata  output  32  instruction word.
- busy  output  1  high in LEN_LO, LEN_HI, DATA, CHECK.
- done  output  1  high in DONE.
- error  output  1  high in ERR.
- cpu_run  output  1  core run enable; high only in DONE.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count, LE), then 4*N data bytes (each word LE, byte 0 = bits 7:0), then 1 checksum byte.
- Checksum = sum of all data bytes mod 256. Length bytes are excluded.
- Reset (rst_n=0 at edge): state IDLE. in_ready, we, waddr, wdata, busy, done, error, cpu_run = 0; words_loaded = 0; internal byte index, word counter and checksum accumulator cleared. Reset mid-load aborts immediately. Memory already written is not cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR. All outputs are registered.
- IDLE: in_ready=0. start -> LEN_LO, clearing words_loaded and checksum.
- LEN_LO: in_ready=1. Accepted byte -> N[7:0], then LEN_HI.
- LEN_HI: in_ready=1. Accepted byte -> N[15:8], then:
  - N > 2^ADDR_W -> ERR;
  - N = 0 -> CHECK;
  - otherwise -> DATA.
- DATA:
  - in_ready=1; each accepted byte is added to the checksum and shifted into the word buffer at byte index 0..3.
  - On acceptance of byte index 3, the next cycle has we=1, waddr=words_loaded (pre-increment value), wdata=the assembled word. words_loaded increments in that same cycle.
  - A new byte may be accepted in the same cycle as the write pulse, so there is no back-pressure and the stream sustains 1 byte/cycle.
  - After the 4th byte of word N-1: -> CHECK.
- CHECK: in_ready=1. Accepted byte equal to the accumulator -> DONE; otherwise -> ERR.
- DONE: cpu_run=1, done=1, in_ready=0.
- ERR: error=1, cpu_run=0, in_ready=0. Words already written remain in memory.
- start in DONE/ERR: -> LEN_LO. cpu_run, done and error drop on the same edge.
- start while busy is ignored.
- in_valid low simply stalls; state and byte index are held.
- in_data is ignored when in_ready=0.
- waddr never wraps: the N bound is checked before DATA is entered. N = 2^ADDR_W is legal and fills memory exactly.
- waddr and wdata hold their last values when we=0.

Test Plan:
- Load N=2 (bytes 02 00 93 00 50 00 13 01 10 00 07) -> we pulses with (0, 0x00500093) and (1, 0x00100113); then done=1, cpu_run=1, error=0, words_loaded=2.
- Same frame with checksum 0x08 -> both writes still occur; error=1, cpu_run=0, done=0.
- N=0 (bytes 00 00 00) -> no we pulse; done=1, cpu_run=1, words_loaded=0. Same with checksum 0x01 -> error=1.
- ADDR_W=6, N=65 (bytes 41 00) -> ERR entered right after LEN_HI; in_ready=0, no writes. Then N=64 with a matching checksum -> 64 writes to addresses 0..63, done=1.
- Scenario 1 with in_valid deasserted randomly for 0-3 cycles between bytes -> identical writes and final state; busy stays high until DONE.
- rst_n low for 1 cycle after 5 data bytes of scenario 1 -> next cycle all outputs 0, state IDLE. Then start plus a full scenario-1 frame -> done=1, words_loaded=2.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream boot loader that fills instruction memory and releases the core
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       buf_q, buf_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_run_q, cpu_run_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [16:0]       words_next_ext;

    assign accept         = in_valid & in_ready_q;
    assign len_full       = {in_data, len_q[7:0]};
    assign words_next_ext = {{(16 - ADDR_W){1'b0}}, words_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        csum_d     = csum_q;
        words_d    = words_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    len_d      = 16'd0;
                    byte_idx_d = 2'd0;
                    csum_d     = 8'd0;
                    words_d    = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    // Bound N here so waddr can never wrap once DATA is entered.
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q + in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = words_q[ADDR_W-1:0];
                        wdata_d = {in_data, buf_q};
                        words_d = words_q + 1'b1;
                        if (words_next_ext == {1'b0, len_q}) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        buf_d = {in_data, buf_q[23:8]};
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                     (state_d == S_DATA)   || (state_d == S_CHECK);
        busy_d     = in_ready_d;
        done_d     = (state_d == S_DONE);
        cpu_run_d  = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            buf_q      <= 24'd0;
            csum_q     <= 8'd0;
            words_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_run_q  <= cpu_run_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign we           = we_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_run      = cpu_run_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_run;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [7:0]        tx_q[$];
    logic [31:0]       wv[0:63];
    logic              busy_bad;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
        .done(done), .error(error), .cpu_run(cpu_run), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", waddr, wdata);
            end else begin
                logic [ADDR_W-1:0] ea;
                logic [31:0]       ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (waddr !== ea || wdata !== ed) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h", waddr, wdata, ea, ed);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 within 20 cycles", in_ready);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'hxx;
    endtask

    // Build a frame of n words from wv[], push expected writes, and queue bytes.
    task automatic prep_frame(input int n, input logic [7:0] cks_xor);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'd0;
        tx_q.delete();
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = wv[i];
            for (int k = 0; k < 4; k++) begin
                tx_q.push_back(w[8*k +: 8]);
                cs = cs + w[8*k +: 8];
            end
            exp_addr.push_back(i[ADDR_W-1:0]);
            exp_data.push_back(w);
        end
        tx_q.push_back(cs ^ cks_xor);
    endtask

    task automatic send_all(input int maxgap, input int poke_at, input int limit);
        int cnt;
        cnt = (limit < 0) ? tx_q.size() : limit;
        for (int i = 0; i < cnt; i++) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (i == poke_at) pulse_start();
            repeat ($urandom_range(maxgap, 0)) begin
                @(posedge clk); #1;
            end
            send_byte(tx_q[i]);
        end
    endtask

    task automatic check_flags(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {in_ready, we, busy, done, error, cpu_run};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: {in_ready,we,busy,done,error,cpu_run}=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_flags("reset_flags", 6'b000000);
        checks++;
        if (words_loaded !== '0 || waddr !== '0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: words=%0d waddr=%0d wdata=%h, expected all 0", words_loaded, waddr, wdata);
        end
    endtask

    task automatic test_load_ok();
        wv[0] = 32'h00500093;
        wv[1] = 32'h00100113;
        prep_frame(2, 8'h00);
        checks++;
        if (tx_q[10] !== 8'h07) begin
            errors++;
            $display("FAIL frame_checksum: got %h, expected 07", tx_q[10]);
        end
        pulse_start();
        send_all(0, -1, -1);
        check_flags("load_ok_flags", 6'b000101);
        checks++;
        if (words_loaded !== 7'd2 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL load_ok_count: words=%0d pending=%0d, expected 2 and 0", words_loaded, exp_addr.size());
        end
    endtask

    task automatic test_bad_checksum();
        prep_frame(2, 8'h0F);
        pulse_start();
        send_all(0, -1, -1);
        check_flags("bad_cks_flags", 6'b000010);
        checks++;
        if (exp_addr.size() != 0 || words_loaded !== 7'd2) begin
            errors++;
            $display("FAIL bad_cks_writes: pending=%0d words=%0d, expected 0 and 2", exp_addr.size(), words_loaded);
        end
    endtask

    task automatic test_zero_len();
        prep_frame(0, 8'h00);
        pulse_start();
        send_all(0, -1, -1);
        check_flags("zero_ok_flags", 6'b000101);
        checks++;
        if (words_loaded !== 7'd0) begin
            errors++;
            $display("FAIL zero_ok_count: words=%0d, expected 0", words_loaded);
        end
        prep_frame(0, 8'h01);
        pulse_start();
        send_all(0, -1, -1);
        check_flags("zero_bad_flags", 6'b000010);
    endtask

    task automatic test_oversize_and_full();
        pulse_start();
        send_byte(8'h41);
        send_byte(8'h00);
        check_flags("oversize_flags", 6'b000010);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (words_loaded !== 7'd0) begin
            errors++;
            $display("FAIL oversize_count: words=%0d, expected 0", words_loaded);
        end
        for (int i = 0; i < 64; i++) wv[i] = $urandom;
        prep_frame(64, 8'h00);
        pulse_start();
        send_all(0, -1, -1);
        check_flags("full_flags", 6'b000101);
        checks++;
        if (words_loaded !== 7'd64 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL full_count: words=%0d pending=%0d, expected 64 and 0", words_loaded, exp_addr.size());
        end
    endtask

    task automatic test_stall();
        wv[0] = 32'h00500093;
        wv[1] = 32'h00100113;
        prep_frame(2, 8'h00);
        busy_bad = 1'b0;
        pulse_start();
        send_all(3, 6, -1);
        checks++;
        if (busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_busy: busy dropped during load, expected held high");
        end
        check_flags("stall_flags", 6'b000101);
        checks++;
        if (words_loaded !== 7'd2 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL stall_count: words=%0d pending=%0d, expected 2 and 0", words_loaded, exp_addr.size());
        end
    endtask

    task automatic test_reset_midload();
        prep_frame(2, 8'h00);
        pulse_start();
        send_all(0, -1, 7);
        checks++;
        if (exp_addr.size() != 1) begin
            errors++;
            $display("FAIL midload_writes: pending=%0d, expected 1", exp_addr.size());
        end
        exp_addr.delete();
        exp_data.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_flags("midload_reset_flags", 6'b000000);
        checks++;
        if (words_loaded !== '0 || waddr !== '0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL midload_reset_regs: words=%0d waddr=%0d wdata=%h, expected all 0", words_loaded, waddr, wdata);
        end
        prep_frame(2, 8'h00);
        pulse_start();
        send_all(0, -1, -1);
        check_flags("reload_flags", 6'b000101);
        checks++;
        if (words_loaded !== 7'd2 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL reload_count: words=%0d pending=%0d, expected 2 and 0", words_loaded, exp_addr.size());
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        busy_bad = 1'b0;
        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_zero_len();
        test_oversize_and_full();
        test_stall();
        test_reset_midload();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
